// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants, the hazard-controller action encoding
// and the pipeline-control bundle each action maps onto.
package mips_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    ACT_RUN   = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2
  } action_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
  } ctl_t;

  localparam ctl_t RESET_CTL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};

  // Pipeline register controls for each sequencing action.
  function automatic ctl_t action_ctl(input action_e act);
    ctl_t c;
    case (act)
      ACT_STALL: c = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
      ACT_FLUSH: c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
      default:   c = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side hazard information in, pipeline sequencing controls out.
interface hazard_stall_ctrl_if
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  logic [REG_W-1:0] IDrs;
  logic [REG_W-1:0] IDrt;
  logic             IDUsesRs;
  logic             IDUsesRt;
  logic             IDReadHILO;
  logic             IDWriteHILO;
  logic             IDMultDiv;
  logic             EXMemRead;
  logic             EXRegWrite;
  logic [REG_W-1:0] EXrt;
  logic             BranchTaken;

  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             MDStart;
  logic             MDBusy;
  logic [CNT_W-1:0] StallCount;

  // Pipeline side: supplies decode/execute state, consumes controls.
  modport master (
    output IDrs, IDrt, IDUsesRs, IDUsesRt, IDReadHILO, IDWriteHILO, IDMultDiv,
           EXMemRead, EXRegWrite, EXrt, BranchTaken,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDStart, MDBusy, StallCount
  );

  // Controller side.
  modport slave (
    input  IDrs, IDrt, IDUsesRs, IDUsesRt, IDReadHILO, IDWriteHILO, IDMultDiv,
           EXMemRead, EXRegWrite, EXrt, BranchTaken,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDStart, MDBusy, StallCount
  );

endinterface

// File: rtl/md_busy_counter.sv
// Tracks how long HI/LO remain pending after a multiply/divide launches.
module md_busy_counter #(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  // A zero latency still needs a 1-bit counter; it simply never loads non-zero.
  localparam int unsigned CW = (MD_LATENCY == 0) ? 1 : $clog2(MD_LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY);

  logic [CW-1:0] md_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt <= '0;
    end else if (start) begin
      md_cnt <= LOAD_VAL;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage sequencing controller: load-use and HI/LO stalls, branch
// flushes, multiply/divide launch and a saturating stall counter.
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  hazard_stall_ctrl_if.slave bus
);

  logic             load_use;
  logic             md_haz;
  logic             md_busy;
  logic             md_start;
  action_e          action;
  ctl_t             ctl;
  logic [CNT_W-1:0] stall_count;

  // Hazard detection against the instruction currently in EX and the HI/LO unit.
  always_comb begin
    load_use = bus.EXMemRead & bus.EXRegWrite & (bus.EXrt != ZERO_REG) &
               ((bus.IDUsesRs & (bus.EXrt == bus.IDrs)) |
                (bus.IDUsesRt & (bus.EXrt == bus.IDrt)));
    md_haz   = md_busy & (bus.IDReadHILO | bus.IDWriteHILO | bus.IDMultDiv);
  end

  // A taken branch squashes the ID instruction, so its stall is moot.
  always_comb begin
    action = ACT_RUN;
    if (bus.BranchTaken) begin
      action = ACT_FLUSH;
    end else if (load_use | md_haz) begin
      action = ACT_STALL;
    end
  end

  always_comb begin
    ctl      = action_ctl(action);
    md_start = bus.IDMultDiv & (action == ACT_RUN);
    if (Rst) begin
      ctl      = RESET_CTL;
      md_start = 1'b0;
    end
  end

  md_busy_counter #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy (
    .clk   (Clk),
    .rst   (Rst),
    .start (md_start),
    .busy  (md_busy)
  );

  // Saturating count of cycles spent stalled.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_count <= '0;
    end else if ((action == ACT_STALL) && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign bus.PCWrite    = ctl.pc_write;
  assign bus.IFIDWrite  = ctl.ifid_write;
  assign bus.IFIDFlush  = ctl.ifid_flush;
  assign bus.IDEXFlush  = ctl.idex_flush;
  assign bus.MDStart    = md_start;
  assign bus.MDBusy     = md_busy & ~Rst;
  assign bus.StallCount = stall_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: a table of per-cycle vectors on a short-latency
// instance plus hand sequences on a long-latency, narrow-counter instance.
module tb_hazard_stall_ctrl;
  import mips_pkg::*;

  // Expected controls packed as {PCWrite,IFIDWrite,IFIDFlush,IDEXFlush,MDStart,MDBusy}
  localparam logic [5:0] C_RUN    = 6'b110000;
  localparam logic [5:0] C_RUNS   = 6'b110010;
  localparam logic [5:0] C_RUNB   = 6'b110001;
  localparam logic [5:0] C_STALL  = 6'b000100;
  localparam logic [5:0] C_STALLB = 6'b000101;
  localparam logic [5:0] C_FLUSH  = 6'b111100;
  localparam logic [5:0] C_FLUSHB = 6'b111101;
  localparam logic [5:0] C_RST    = 6'b001100;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(32)) bus_a ();
  hazard_stall_ctrl_if #(.CNT_W(3))  bus_b ();

  hazard_stall_ctrl #(.MD_LATENCY(4),  .CNT_W(32)) u_a (.Clk(clk), .Rst(rst_a), .bus(bus_a.slave));
  hazard_stall_ctrl #(.MD_LATENCY(32), .CNT_W(3))  u_b (.Clk(clk), .Rst(rst_b), .bus(bus_b.slave));

  typedef struct {
    logic        rst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urs;
    logic        urt;
    logic        rhilo;
    logic        whilo;
    logic        md;
    logic        exmr;
    logic        exrw;
    logic [4:0]  exrt;
    logic        br;
    logic [5:0]  ctl;
    int unsigned cnt;
  } vec_t;

  typedef struct {
    string       name;
    bit          sel_b;
    logic [5:0]  ctl;
    int unsigned cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic rhilo,
                              input logic whilo, input logic md, input logic exmr,
                              input logic exrw, input logic [4:0] exrt, input logic br,
                              input logic [5:0] ctl, input int unsigned cnt);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.rhilo = rhilo; v.whilo = whilo; v.md = md; v.exmr = exmr; v.exrw = exrw;
    v.exrt = exrt; v.br = br; v.ctl = ctl; v.cnt = cnt;
    return v;
  endfunction

  function automatic vec_t idle(input logic rst);
    return mk(rst, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0, C_RUN, 0);
  endfunction

  task automatic drive_a(input vec_t v);
    rst_a = v.rst;
    bus_a.IDrs = v.rs; bus_a.IDrt = v.rt; bus_a.IDUsesRs = v.urs; bus_a.IDUsesRt = v.urt;
    bus_a.IDReadHILO = v.rhilo; bus_a.IDWriteHILO = v.whilo; bus_a.IDMultDiv = v.md;
    bus_a.EXMemRead = v.exmr; bus_a.EXRegWrite = v.exrw; bus_a.EXrt = v.exrt;
    bus_a.BranchTaken = v.br;
  endtask

  task automatic drive_b(input vec_t v);
    rst_b = v.rst;
    bus_b.IDrs = v.rs; bus_b.IDrt = v.rt; bus_b.IDUsesRs = v.urs; bus_b.IDUsesRt = v.urt;
    bus_b.IDReadHILO = v.rhilo; bus_b.IDWriteHILO = v.whilo; bus_b.IDMultDiv = v.md;
    bus_b.EXMemRead = v.exmr; bus_b.EXRegWrite = v.exrw; bus_b.EXrt = v.exrt;
    bus_b.BranchTaken = v.br;
  endtask

  task automatic check();
    exp_t        e;
    logic [5:0]  got_ctl;
    int unsigned got_cnt;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
      return;
    end
    e = sb.pop_front();
    if (e.sel_b) begin
      got_ctl = {bus_b.PCWrite, bus_b.IFIDWrite, bus_b.IFIDFlush, bus_b.IDEXFlush, bus_b.MDStart, bus_b.MDBusy};
      got_cnt = 32'(bus_b.StallCount);
    end else begin
      got_ctl = {bus_a.PCWrite, bus_a.IFIDWrite, bus_a.IFIDFlush, bus_a.IDEXFlush, bus_a.MDStart, bus_a.MDBusy};
      got_cnt = bus_a.StallCount;
    end
    n_cmp++;
    if (got_ctl !== e.ctl) begin
      n_bad++;
      $display("FAIL %s ctl: got %b required %b", e.name, got_ctl, e.ctl);
    end
    n_cmp++;
    if (got_cnt !== e.cnt) begin
      n_bad++;
      $display("FAIL %s StallCount: got %0d required %0d", e.name, got_cnt, e.cnt);
    end
  endtask

  // Drive one cycle of stimulus on the selected instance and check it mid-cycle.
  task automatic apply(input vec_t v, input bit sel_b, input string name);
    exp_t e;
    @(negedge clk);
    drive_a(sel_b ? idle(1'b0) : v);
    drive_b(sel_b ? v : idle(1'b0));
    e.name = name; e.sel_b = sel_b; e.ctl = v.ctl; e.cnt = v.cnt;
    sb.push_back(e);
    #1;
    check();
  endtask

  initial begin
    // rst rs rt urs urt rhilo whilo md exmr exrw exrt br ctl cnt
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST,    0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,    0));
    tbl.push_back(mk(0, 8, 0, 1, 0, 0, 0, 0, 1, 1, 8, 0, C_STALL,  0));
    tbl.push_back(mk(0, 8, 0, 1, 0, 0, 0, 0, 0, 0, 8, 0, C_RUN,    1));
    tbl.push_back(mk(0, 0, 9, 0, 1, 0, 0, 0, 1, 1, 9, 0, C_STALL,  1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, C_RUN,    2));
    tbl.push_back(mk(0, 8, 3, 0, 1, 0, 0, 0, 1, 1, 8, 0, C_RUN,    2));
    tbl.push_back(mk(0, 8, 0, 1, 0, 0, 0, 0, 1, 0, 8, 0, C_RUN,    2));
    tbl.push_back(mk(0, 8, 0, 1, 0, 0, 0, 0, 1, 1, 8, 1, C_FLUSH,  2));
    tbl.push_back(mk(0, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,    2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_FLUSH,  2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_RUNS,   2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_STALLB, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_STALLB, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_STALLB, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_STALLB, 5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_RUN,    6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_RUNS,   6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_STALLB, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_STALLB, 7));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_STALLB, 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_STALLB, 9));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_RUNS,  10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUNB,  10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_FLUSHB,10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUNB,  10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_STALLB,10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, C_RUN,   11));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, C_FLUSH, 11));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   11));

    // Bring both instances out of reset before any checking.
    drive_a(idle(1'b1));
    drive_b(idle(1'b1));
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], 1'b0, $sformatf("tbl_a[%0d]", i));
    end

    // Saturation: MULT, then MFHI held against a 32-cycle busy period, 3-bit counter.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_RUNS, 0), 1'b1, "sat_mult");
    for (int i = 0; i < 11; i++) begin
      apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_STALLB, (i > 7) ? 7 : i),
            1'b1, $sformatf("sat_stall[%0d]", i));
    end
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 7), 1'b1, "sat_rst");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0), 1'b1, "sat_cleared");

    // Reset in cycle 2 of a fresh 32-cycle busy period.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_RUNS,   0), 1'b1, "rb_mult");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_STALLB, 0), 1'b1, "rb_busy1");
    apply(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_RST,    1), 1'b1, "rb_rst");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_RUN,    0), 1'b1, "rb_after1");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, C_RUN,    0), 1'b1, "rb_after2");

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath.
- Drives PC write enable, IF/ID write enable and flush, and the ID/EX register reset (bubble insertion).
- Detects load-use hazards, branch-taken flushes and multi-cycle MULT/DIV occupancy of HI/LO.
- Keeps a stall performance counter.
- Sits beside the decode stage; its IDEXFlush output is OR'd into the ID/EX pipeline register's Rst input.

Parameters:
- MD_LATENCY, 32, cycles HI/LO stay busy after a MULT/DIV issues; 0 means single-cycle (never busy).
- CNT_W, 32, width of the stall performance counter.

Ports:
- Clk  input  1  clock, all state updates on posedge
- Rst  input  1  synchronous, active-high reset
- IDrs  input  5  rs field of the instruction in ID
- IDrt  input  5  rt field of the instruction in ID
- IDUsesRs  input  1  ID instruction reads rs
- IDUsesRt  input  1  ID instruction reads rt
- IDReadHILO  input  1  ID instruction is MFHI/MFLO (ReadHI or ReadLO)
- IDWriteHILO  input  1  ID instruction is MTHI/MTLO
- IDMultDiv  input  1  ID instruction is MULT/MULTU/DIV/DIVU
- EXMemRead  input  1  MemRead of the instruction in EX
- EXRegWrite  input  1  RegWrite of the instruction in EX
- EXrt  input  5  load destination (rt) of the instruction in EX
- BranchTaken  input  1  branch/jump resolved taken in EX this cycle
- PCWrite  output  1  PC load enable
- IFIDWrite  output  1  IF/ID register load enable
- IFIDFlush  output  1  clear the IF/ID register to NOP
- IDEXFlush  output  1  zero the ID/EX register (bubble)
- MDStart  output  1  launch the multiply/divide unit this cycle
- MDBusy  output  1  HI/LO result is still pending
- StallCount  output  CNT_W  saturating count of stall cycles

Behaviour:
- All outputs are combinational from the inputs and registered state, so they act in the same cycle.
- The only registered state is MdCnt (width $clog2(MD_LATENCY+1)) and StallCount.
- Reset, while Rst=1:
  - PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1, MDStart=0, MDBusy=0.
  - On the next edge, MdCnt<=0 and StallCount<=0.
  - Reset asserted mid-operation aborts any busy period immediately.
- LoadUse = EXMemRead & EXRegWrite & (EXrt!=0) & ((IDUsesRs & EXrt==IDrs) | (IDUsesRt & EXrt==IDrt)).
- MDBusy = (MdCnt != 0).
- MdHaz = MDBusy & (IDReadHILO | IDWriteHILO | IDMultDiv).
- Priority (highest first):
  - Rst.
  - BranchTaken: FLUSH.
  - LoadUse | MdHaz: STALL.
  - Otherwise: RUN.
- RUN: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXFlush=0.
- STALL: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXFlush=1. The ID instruction is held and a bubble enters EX.
- FLUSH: PCWrite=1 (PC takes the target), IFIDWrite=1, IFIDFlush=1, IDEXFlush=1.
  - A simultaneous stall condition is discarded, because the ID instruction is squashed.
- MDStart = IDMultDiv & RUN. It is never asserted in STALL or FLUSH.
- MdCnt update:
  - If MDStart, load MD_LATENCY.
  - Else if MdCnt != 0, decrement.
  - MDStart in cycle T gives MDBusy=1 for cycles T+1 .. T+MD_LATENCY.
  - A BranchTaken during busy does not cancel the in-flight operation.
- StallCount increments on each edge where STALL holds. It saturates at 2^CNT_W-1 (no wrap).
- A stall lasts exactly as long as its condition holds:
  - LoadUse clears after 1 cycle, because a bubble occupies EX.
  - MdHaz clears on the first cycle MDBusy=0.

Decomposition:
- Shared package (mips_pkg):
  - Register index width constant (REG_W=5).
  - Zero-register constant.
  - Optional localparam enum for the RUN/STALL/FLUSH action encoding, used by assertions and debug.
- One natural sub-module: md_busy_counter (load / decrement / busy flag, parameterised by MD_LATENCY).

Test Plan:
- Load-use:
  - Stimulus: EXMemRead=1, EXRegWrite=1, EXrt=8, IDrs=8, IDUsesRs=1.
  - Required: PCWrite=0, IFIDWrite=0, IDEXFlush=1 for exactly 1 cycle; StallCount 0->1.
  - Repeat with EXrt=0: no stall.
- MULT then MFHI (MD_LATENCY=4):
  - Stimulus: IDMultDiv=1 at cycle 0, IDReadHILO=1 from cycle 1.
  - Required: MDStart=1 at cycle 0; stall during cycles 1-4; RUN at cycle 5; StallCount=4.
- Branch versus stall:
  - Stimulus: BranchTaken=1 in the same cycle as a LoadUse match.
  - Required: IFIDFlush=1, IDEXFlush=1, PCWrite=1; StallCount unchanged.
- Back-to-back MULT (MD_LATENCY=4):
  - Stimulus: a second IDMultDiv while busy.
  - Required: it stalls until MdCnt=0, then MDStart and MdCnt reloads to 4.
- Reset mid-busy:
  - Stimulus: Rst=1 at cycle 2 of a 32-cycle busy period.
  - Required: MDBusy=0 and StallCount=0 after the edge; IFIDFlush=IDEXFlush=1 while Rst=1.
- Saturation (CNT_W=3):
  - Stimulus: hold MdHaz for 10 cycles.
  - Required: StallCount stops at 7.
